// File: rtl/ctrl_step_seq.sv
// Step sequencer: walks the control code x from 0 to LAST, holding each value
// for DIV cycles, in one-shot or continuous mode. Every output is registered.
module ctrl_step_seq #(
  parameter int DIV  = 2,
  parameter int LAST = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  output logic [3:0] x,
  output logic       busy,
  output logic       done,
  output logic       step
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  localparam logic [3:0] LAST_X = 4'(LAST);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic       mode_q, mode_d;
  logic [3:0] x_d;
  logic       busy_d, done_d, step_d;
  logic       tick;

  // Handshake: start/stop are plain levels sampled on every rising edge; there
  // is no ready/valid pair. stop beats start in IDLE and beats a tick in RUN.
  assign tick = (presc_q == DIV_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      mode_q  <= 1'b0;
      x       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      step    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      x       <= x_d;
      busy    <= busy_d;
      done    <= done_d;
      step    <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    x_d     = x;
    busy_d  = busy;
    done_d  = 1'b0;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        x_d    = '0;
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          presc_d = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          presc_d = '0;
          x_d     = '0;
          busy_d  = 1'b0;
        end else if (tick) begin
          presc_d = '0;
          if (x < LAST_X) begin
            x_d    = x + 4'd1;
            step_d = 1'b1;
          end else if (mode_q) begin
            // continuous: wrap to 0, the new x=0 counts as a fresh step
            x_d    = '0;
            done_d = 1'b1;
            step_d = 1'b1;
          end else begin
            state_d = IDLE;
            x_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        x_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_step_seq.sv
// Bench for ctrl_step_seq: two parameterisations share one stimulus stream; a
// cycle-position model predicts each cycle's outputs into per-instance queues.
module tb_ctrl_step_seq;

  localparam int DIV_A = 2, LAST_A = 15;
  localparam int DIV_B = 1, LAST_B = 3;

  typedef struct {
    bit run;
    bit md;
    int cnt;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] x_a, x_b;
  logic       busy_a, done_a, step_a;
  logic       busy_b, done_b, step_b;

  logic [6:0] exp_a[$];
  logic [6:0] exp_b[$];
  mdl_t       m_a, m_b;
  int         checks = 0;
  int         errors = 0;
  int         busy_cnt_a = 0;
  int         busy_cnt_b = 0;

  always #5 clk = ~clk;

  ctrl_step_seq #(.DIV(DIV_A), .LAST(LAST_A)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .x(x_a), .busy(busy_a), .done(done_a), .step(step_a)
  );

  ctrl_step_seq #(.DIV(DIV_B), .LAST(LAST_B)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .x(x_b), .busy(busy_b), .done(done_b), .step(step_b)
  );

  // Reference: a run is a count of cycles since start; x = cnt/DIV, a step is
  // every multiple of DIV, and a run completes after (LAST+1)*DIV cycles.
  task automatic model_step(input int div, input int last, input mdl_t s,
                            input bit r, input bit st, input bit sp, input bit md,
                            output mdl_t n, output logic [6:0] e);
    n = s;
    e = '0;
    if (r) begin
      n.run = 1'b0;
      n.md  = 1'b0;
      n.cnt = 0;
    end else if (!s.run) begin
      if (st && !sp) begin
        n.run = 1'b1;
        n.md  = md;
        n.cnt = 0;
        e     = 7'b0000_100;
      end
    end else if (sp) begin
      n.run = 1'b0;
    end else begin
      n.cnt = s.cnt + 1;
      if (n.cnt == (last + 1) * div) begin
        n.cnt = 0;
        if (s.md) e = 7'b0000_111;
        else begin
          n.run = 1'b0;
          e     = 7'b0000_010;
        end
      end else begin
        e = {4'(n.cnt / div), 1'b1, 1'b0, 1'((n.cnt % div) == 0)};
      end
    end
  endtask

  // Drive one clock edge's inputs and queue what each instance must show after it.
  task automatic cyc(input bit r, input bit st, input bit sp, input bit md);
    logic [6:0] ea, eb;
    mdl_t na, nb;
    @(negedge clk);
    rst   = r;
    start = st;
    stop  = sp;
    mode  = md;
    model_step(DIV_A, LAST_A, m_a, r, st, sp, md, na, ea);
    model_step(DIV_B, LAST_B, m_b, r, st, sp, md, nb, eb);
    m_a = na;
    m_b = nb;
    exp_a.push_back(ea);
    exp_b.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_a.size() > 0) begin
      logic [6:0] e, a;
      e = exp_a.pop_front();
      a = {x_a, busy_a, done_a, step_a};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL out_a t=%0t got x=%0d busy=%b done=%b step=%b want x=%0d busy=%b done=%b step=%b",
                 $time, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
      end
      if (busy_a === 1'b1) busy_cnt_a++;
    end
    if (exp_b.size() > 0) begin
      logic [6:0] e, a;
      e = exp_b.pop_front();
      a = {x_b, busy_b, done_b, step_b};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL out_b t=%0t got x=%0d busy=%b done=%b step=%b want x=%0d busy=%b done=%b step=%b",
                 $time, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
      end
      if (busy_b === 1'b1) busy_cnt_b++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got checks=%0d want run to finish", checks);
    $fatal(1);
  end

  initial begin
    m_a = '{run: 1'b0, md: 1'b0, cnt: 0};
    m_b = '{run: 1'b0, md: 1'b0, cnt: 0};

    // reset held with start high, then released
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // one-shot run; the B instance also restarts in the cycle its done is high
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    busy_cnt_a = 0;
    busy_cnt_b = 0;
    idle(4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    busy_cnt_b = 0;
    idle(34);
    settle();
    checks++;
    if (busy_cnt_a != 32) begin
      errors++;
      $display("FAIL busy_len_a got %0d want 32", busy_cnt_a);
    end
    checks++;
    if (busy_cnt_b != 4) begin
      errors++;
      $display("FAIL busy_len_b got %0d want 4", busy_cnt_b);
    end

    // continuous, two wraps, then stop
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(70);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // stop at x=5, then start+stop together in idle
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // reset mid-run at x=9
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(18);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // start ignored while running (mode change must not be latched)
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(40);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
    end
    idle(2);
    settle();

    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", exp_a.size(), exp_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_step_seq.md
# ctrl_step_seq

Step sequencer that drives the 4-bit control code `x` consumed by the datapath control decoder, which turns `x` into mux select lines `s1`/`s0`. It advances `x` from 0 to `LAST`, holding each value for `DIV` clock cycles. It supports one-shot and continuous modes, with start/stop control, a busy flag, and done and step pulses. It is the stage directly upstream of the control decoder.

## Interface
- `DIV`, default 2: clock cycles per step; legal range 1..256.
- `LAST`, default 15: final code value before completion; legal range 0..15.

- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  level-sampled; begins a sequence when idle.
- `stop`  in  1  level-sampled; aborts a running sequence.
- `mode`  in  1  0 = one-shot, 1 = continuous; sampled only when `start` is accepted.
- `x`  out  4  current step code; feeds the control decoder.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `step`  out  1  one-cycle pulse in the first cycle of each new `x` value within a run.

## Operation
- Reset (`rst`=1 at an edge): state IDLE, `x`=0, `busy`=0, `done`=0, `step`=0, prescaler=0, latched mode=0. `rst` overrides all other inputs.
- All outputs are registered. The prescaler is an 8-bit counter, 0..DIV-1.
- IDLE:
  - `x`=0, `busy`=0.
  - `start`=1 and `stop`=0: go to RUN, latch `mode`, clear prescaler, keep `x`=0.
  - `start` and `stop` both high: stop wins; remain IDLE.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler = DIV-1 (a tick), prescaler returns to 0. With DIV=1, every RUN cycle is a tick.
  - Tick with `x` < LAST: `x` <= `x`+1, `step`=1 next cycle.
  - Tick with `x` = LAST, one-shot: next cycle IDLE, `x`=0, `busy`=0, `done`=1, `step`=0.
  - Tick with `x` = LAST, continuous: next cycle stay RUN, `x`=0, `done`=1, `step`=1.
  - `stop`=1: next cycle IDLE, `x`=0, `busy`=0, `done`=0, `step`=0. This holds even if the same cycle is a tick at LAST.
  - `start` is ignored while in RUN.
- LAST=0:
  - One-shot completes after DIV cycles with `x`=0 throughout.
  - Continuous pulses `done` every DIV cycles with `step`=1.
- `x` never exceeds LAST. No arithmetic overflow is possible, since LAST ≤ 15 fits in 4 bits.

## Timing
- `start` sampled at edge k gives `busy`=1, `x`=0 in cycle k+1.
- Each value `n` occupies cycles k+1+n·DIV through k+(n+1)·DIV.
- One-shot run:
  - `busy` is high for exactly (LAST+1)·DIV cycles.
  - `done` is high in cycle k+1+(LAST+1)·DIV, coincident with `busy`=0.
- A new `start` may be accepted in the same cycle `done` is high. Busy then rises in the following cycle.
- `stop` latency is 1 cycle. `rst` latency is 1 cycle.
- `done` and `step` never exceed one cycle per event.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `start`=1 → `x`=0, `busy`=0, `done`=0, `step`=0 throughout and on the first cycle after release.
- One-shot, DIV=2, LAST=15, `start` pulsed at edge 0:
  - `busy`=1 in cycles 1..32.
  - `x`=n in cycles 1+2n and 2+2n.
  - `step`=1 in cycles 3, 5, …, 31.
  - `done`=1 with `busy`=0 and `x`=0 in cycle 33 only.
- Continuous, DIV=2, LAST=15:
  - After `x`=15 in cycles 31..32, cycle 33 has `x`=0, `busy`=1, `done`=1, `step`=1.
  - The second wrap gives `done`=1 in cycle 65.
- Stop:
  - Assert `stop` while `x`=5 → next cycle `x`=0, `busy`=0, `done`=0.
  - `start` and `stop` together in IDLE → stays IDLE, `busy`=0.
- Reset and start priority:
  - `rst` at `x`=9 → next cycle all outputs 0.
  - `start` pulsed while `x`=4 → sequence continues unchanged to `x`=5 at the next tick.
- DIV=1, LAST=3, one-shot:
  - `start` at edge 0 → `x`=0, 1, 2, 3 in cycles 1..4.
  - `done`=1, `busy`=0 in cycle 5.
  - Restart via `start` at edge 5 → `busy`=1 in cycle 6.
